// File: rtl/mem_read_responder.sv
// Memory-side responder for the rd/ws/ds read handshake: programmable wait states,
// auto-incrementing read pointer and a software-loadable local buffer.
module mem_read_responder #(
   parameter int DW = 8,
   parameter int AW = 4,
   parameter int WW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          rd,
   input  logic          ds,
   input  logic [WW-1:0] wait_cfg,
   input  logic          ld_en,
   input  logic [AW-1:0] ld_addr,
   input  logic [DW-1:0] ld_data,
   output logic          ws,
   output logic          rvalid,
   output logic [DW-1:0] rdata,
   output logic [AW-1:0] rptr,
   output logic          done,
   output logic          abort
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DATA} state_t;

   state_t        state, state_nx;
   logic [WW-1:0] cnt, cnt_nx;
   logic [AW-1:0] rptr_nx;
   logic          capture;
   logic          done_nx;
   logic          abort_nx;

   logic [DW-1:0] mem [0:(1<<AW)-1];

   // Buffer contents survive reset; loads are accepted in any state.
   always_ff @(posedge clk) begin
      if (ld_en) mem[ld_addr] <= ld_data;
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      rptr_nx  = rptr;
      capture  = 1'b0;
      done_nx  = 1'b0;
      abort_nx = 1'b0;
      case (state)
         S_IDLE: begin
            if (rd) begin
               if (wait_cfg == '0) begin
                  state_nx = S_DATA;
                  capture  = 1'b1;
               end else begin
                  state_nx = S_WAIT;
                  cnt_nx   = wait_cfg;
               end
            end
         end
         S_WAIT: begin
            if (!rd) begin
               state_nx = S_IDLE;
               abort_nx = 1'b1;
            end else if (cnt == WW'(1)) begin
               state_nx = S_DATA;
               capture  = 1'b1;
            end else begin
               cnt_nx = cnt - WW'(1);
            end
         end
         S_DATA: begin
            // The controller drops rd together with ds, so ds wins over rd.
            if (ds) begin
               state_nx = S_IDLE;
               done_nx  = 1'b1;
               rptr_nx  = rptr + AW'(1);
            end else if (!rd) begin
               state_nx = S_IDLE;
               abort_nx = 1'b1;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Capturing with a non-blocking read gives read-before-write against the load port.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
         cnt   <= '0;
         rptr  <= '0;
         rdata <= '0;
         done  <= 1'b0;
         abort <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         rptr  <= rptr_nx;
         done  <= done_nx;
         abort <= abort_nx;
         if (capture) rdata <= mem[rptr];
      end
   end

   assign ws     = (state == S_WAIT);
   assign rvalid = (state == S_DATA);

endmodule

// File: tb/tb_mem_read_responder.sv
// Directed bench for mem_read_responder: handshake, wait states, wrap, abort,
// read-before-write on the load port and asynchronous reset.
module tb_mem_read_responder;

   logic       clk = 1'b0;
   logic       rst;
   logic       rd, ds;
   logic [3:0] wait_cfg;
   logic       ld_en;
   logic [3:0] ld_addr;
   logic [7:0] ld_data;
   logic       ws, rvalid, done, abort;
   logic [7:0] rdata;
   logic [3:0] rptr;

   int errors = 0;
   int checks = 0;

   mem_read_responder #(.DW(8), .AW(4), .WW(4)) dut (
      .clk(clk), .rst(rst), .rd(rd), .ds(ds), .wait_cfg(wait_cfg),
      .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
      .ws(ws), .rvalid(rvalid), .rdata(rdata), .rptr(rptr),
      .done(done), .abort(abort)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [3:0] a, input logic [7:0] d);
      ld_en = 1'b1; ld_addr = a; ld_data = d;
      step();
      ld_en = 1'b0;
   endtask

   // Zero-wait access used only to move the read pointer.
   task automatic quick_access();
      wait_cfg = 4'd0; rd = 1'b1;
      step();
      ds = 1'b1; rd = 1'b0;
      step();
      ds = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0; rd = 1'b0; ds = 1'b0; wait_cfg = 4'd0;
      ld_en = 1'b0; ld_addr = 4'd0; ld_data = 8'd0;
      step();
      checks++;
      if ({ws, rvalid, done, abort, rdata, rptr} !== 16'h0) begin
         errors++;
         $display("FAIL reset_outputs got ws=%b rvalid=%b done=%b abort=%b rdata=%h rptr=%h want all 0",
                  ws, rvalid, done, abort, rdata, rptr);
      end
      // Preload while still in reset: the buffer is not under reset.
      for (int i = 0; i < 16; i++) begin
         case (i)
            0:       load(4'(i), 8'hA5);
            1:       load(4'(i), 8'h3C);
            15:      load(4'(i), 8'hE1);
            default: load(4'(i), 8'(8'h40 + i));
         endcase
      end
      rst = 1'b1;
      step();
   endtask

   task automatic test_idle_ds_ignored();
      ds = 1'b1;
      step();
      step();
      ds = 1'b0;
      checks++;
      if (done !== 1'b0 || rvalid !== 1'b0 || rptr !== 4'd0) begin
         errors++;
         $display("FAIL idle_ds got done=%b rvalid=%b rptr=%h want 0 0 0", done, rvalid, rptr);
      end
   endtask

   task automatic test_zero_wait();
      int wsn = 0;
      wait_cfg = 4'd0; rd = 1'b1;
      step();
      if (ws) wsn++;
      checks++;
      if (rvalid !== 1'b1 || rdata !== 8'hA5) begin
         errors++;
         $display("FAIL zw_data got rvalid=%b rdata=%h want 1 a5", rvalid, rdata);
      end
      ds = 1'b1; rd = 1'b0;
      step();
      if (ws) wsn++;
      ds = 1'b0;
      checks++;
      if (done !== 1'b1 || abort !== 1'b0 || rptr !== 4'd1 || rvalid !== 1'b0) begin
         errors++;
         $display("FAIL zw_done got done=%b abort=%b rptr=%h rvalid=%b want 1 0 1 0", done, abort, rptr, rvalid);
      end
      step();
      checks++;
      if (done !== 1'b0 || wsn != 0) begin
         errors++;
         $display("FAIL zw_pulse got done=%b ws_cycles=%0d want 0 0", done, wsn);
      end
   endtask

   task automatic test_wait_states();
      int  wsn = 0;
      bit  seen = 0;
      wait_cfg = 4'd3; rd = 1'b1;
      step();
      wait_cfg = 4'd0;  // must not affect the access in flight
      for (int i = 0; i < 20 && !seen; i++) begin
         if (ws) wsn++;
         if (rvalid) seen = 1;
         else step();
      end
      checks++;
      if (!seen || wsn != 3) begin
         errors++;
         $display("FAIL ws_count got rvalid_seen=%0d ws_cycles=%0d want 1 3", seen, wsn);
      end
      checks++;
      if (rdata !== 8'h3C || ws !== 1'b0) begin
         errors++;
         $display("FAIL ws_data got rdata=%h ws=%b want 3c 0", rdata, ws);
      end
      step();
      checks++;
      if (rvalid !== 1'b1 || rdata !== 8'h3C) begin
         errors++;
         $display("FAIL ws_hold got rvalid=%b rdata=%h want 1 3c", rvalid, rdata);
      end
      ds = 1'b1; rd = 1'b0;
      step();
      ds = 1'b0;
      checks++;
      if (done !== 1'b1 || rptr !== 4'd2) begin
         errors++;
         $display("FAIL ws_done got done=%b rptr=%h want 1 2", done, rptr);
      end
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 13; i++) quick_access();
      checks++;
      if (rptr !== 4'hF) begin
         errors++;
         $display("FAIL wrap_pre got rptr=%h want f", rptr);
      end
      wait_cfg = 4'd1; rd = 1'b1;
      step();
      step();
      checks++;
      if (rvalid !== 1'b1 || rdata !== 8'hE1) begin
         errors++;
         $display("FAIL wrap_data got rvalid=%b rdata=%h want 1 e1", rvalid, rdata);
      end
      ds = 1'b1; rd = 1'b0;
      step();
      ds = 1'b0;
      checks++;
      if (done !== 1'b1 || rptr !== 4'h0) begin
         errors++;
         $display("FAIL wrap_ptr got done=%b rptr=%h want 1 0", done, rptr);
      end
   endtask

   task automatic test_abort();
      step();
      wait_cfg = 4'd5; rd = 1'b1;
      step();
      step();
      checks++;
      if (ws !== 1'b1) begin
         errors++;
         $display("FAIL abort_ws got ws=%b want 1", ws);
      end
      rd = 1'b0;
      step();
      checks++;
      if (abort !== 1'b1 || done !== 1'b0 || ws !== 1'b0 || rptr !== 4'h0) begin
         errors++;
         $display("FAIL abort_pulse got abort=%b done=%b ws=%b rptr=%h want 1 0 0 0", abort, done, ws, rptr);
      end
      step();
      checks++;
      if (abort !== 1'b0) begin
         errors++;
         $display("FAIL abort_len got abort=%b want 0", abort);
      end
      wait_cfg = 4'd0; rd = 1'b1;
      step();
      checks++;
      if (rdata !== 8'hA5) begin
         errors++;
         $display("FAIL abort_reread got rdata=%h want a5", rdata);
      end
      ds = 1'b1; rd = 1'b0;
      step();
      ds = 1'b0;
      checks++;
      if (rptr !== 4'h1) begin
         errors++;
         $display("FAIL abort_next got rptr=%h want 1", rptr);
      end
   endtask

   task automatic test_read_before_write();
      load(4'h1, 8'h11);
      wait_cfg = 4'd0; rd = 1'b1;
      ld_en = 1'b1; ld_addr = 4'h1; ld_data = 8'h77;
      step();
      ld_en = 1'b0;
      checks++;
      if (rdata !== 8'h11) begin
         errors++;
         $display("FAIL rbw_old got rdata=%h want 11", rdata);
      end
      ds = 1'b1; rd = 1'b0;
      step();
      ds = 1'b0;
      for (int i = 0; i < 15; i++) quick_access();
      checks++;
      if (rptr !== 4'h1) begin
         errors++;
         $display("FAIL rbw_ptr got rptr=%h want 1", rptr);
      end
      wait_cfg = 4'd0; rd = 1'b1;
      step();
      checks++;
      if (rdata !== 8'h77) begin
         errors++;
         $display("FAIL rbw_new got rdata=%h want 77", rdata);
      end
      ds = 1'b1; rd = 1'b0;
      step();
      ds = 1'b0;
   endtask

   task automatic test_async_reset();
      wait_cfg = 4'd4; rd = 1'b1;
      step();
      step();
      checks++;
      if (ws !== 1'b1 || rptr !== 4'h2 || rdata !== 8'h77) begin
         errors++;
         $display("FAIL arst_pre got ws=%b rptr=%h rdata=%h want 1 2 77", ws, rptr, rdata);
      end
      #1 rst = 1'b0;
      #1;
      checks++;
      if ({ws, rvalid, done, abort, rdata, rptr} !== 16'h0) begin
         errors++;
         $display("FAIL arst_clear got ws=%b rvalid=%b done=%b abort=%b rdata=%h rptr=%h want all 0",
                  ws, rvalid, done, abort, rdata, rptr);
      end
      rd = 1'b0;
      step();
      rst = 1'b1;
      step();
      step();
      checks++;
      if (done !== 1'b0 || abort !== 1'b0 || ws !== 1'b0) begin
         errors++;
         $display("FAIL arst_after got done=%b abort=%b ws=%b want 0 0 0", done, abort, ws);
      end
   endtask

   initial begin
      test_reset();
      test_idle_ds_ignored();
      test_zero_wait();
      test_wait_states();
      test_wrap();
      test_abort();
      test_read_before_write();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
